// File: rtl/mem_arbiter_nch_pkg.sv
// mem_arbiter_nch_pkg: shared state, size and flag encodings for the byte-serial RAM arbiter
package mem_arbiter_nch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
   localparam logic [2:0] SZ_1 = 3'd1;
   localparam logic [2:0] SZ_2 = 3'd2;
   localparam logic FLAG_READ = 1'b0;
   localparam logic FLAG_WRITE = 1'b1;
   localparam logic [1:0] IO_HI_DEF = 2'b11;
endpackage

// File: rtl/mem_arbiter_nch_if.sv
// mem_arbiter_nch_if: requester, RAM and control signals between the arbiter and its surroundings
interface mem_arbiter_nch_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic rdy;
   logic flush_i;
   logic io_full_i;
   logic ram_we_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [7:0] ram_din_i;
   logic [7:0] ram_dout_o;
   logic [NUM_CH-1:0] req_valid_i;
   logic [NUM_CH-1:0] req_we_i;
   logic [NUM_CH-1:0] req_signed_i;
   logic [NUM_CH*3-1:0] req_size_i;
   logic [NUM_CH*ADDR_W-1:0] req_addr_i;
   logic [NUM_CH*DATA_W-1:0] req_wdata_i;
   logic [NUM_CH-1:0] done_o;
   logic [DATA_W-1:0] rdata_o;
   modport master (
      output rdy, flush_i, io_full_i, ram_din_i, req_valid_i, req_we_i, req_signed_i,
             req_size_i, req_addr_i, req_wdata_i,
      input  ram_we_o, ram_addr_o, ram_dout_o, done_o, rdata_o
   );
   modport slave (
      input  rdy, flush_i, io_full_i, ram_din_i, req_valid_i, req_we_i, req_signed_i,
             req_size_i, req_addr_i, req_wdata_i,
      output ram_we_o, ram_addr_o, ram_dout_o, done_o, rdata_o
   );
endinterface

// File: rtl/mem_arbiter_nch_arb_pick.sv
// mem_arbiter_nch_arb_pick: one-hot grant picker; fixed priority, or round-robin when MEM_ARB_RR_EN is defined
module mem_arbiter_nch_arb_pick #(
   parameter int NUM_CH = 2
) (
`ifdef MEM_ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic adv,
`endif
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt
);
`ifdef MEM_ARB_RR_EN
   localparam int PW = $clog2(NUM_CH);
   logic [PW-1:0] ptr, idx, win;
   // search starts just past the last winner so every requester gets a turn
   always_comb begin
      gnt = '0;
      win = ptr;
      idx = '0;
      for (int i = NUM_CH; i >= 1; i--) begin
         idx = PW'((int'(ptr) + i) % NUM_CH);
         if (req[idx]) begin
            gnt = NUM_CH'(1) << idx;
            win = idx;
         end
      end
   end
   // pointer resets to the last channel so channel 0 wins the first contest
   always_ff @(posedge clk) ptr <= rst ? PW'(NUM_CH - 1) : (adv && |req) ? win : ptr;
`else
   // lowest index wins
   always_comb begin
      gnt = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (req[i]) gnt = NUM_CH'(1) << i;
   end
`endif
endmodule

// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: byte-serial RAM controller for NUM_CH requesters; MEM_ARB_RR_EN selects round-robin arbitration
module mem_arbiter_nch
   import mem_arbiter_nch_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter logic [NUM_CH-1:0] FLUSH_MASK = 2'b10,
   parameter logic [1:0] IO_HI = IO_HI_DEF
) (
   input logic clk,
   input logic rst,
   mem_arbiter_nch_if.slave bus
);
   localparam int MAX_B = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_B + 1);
   localparam int CW = $clog2(NUM_CH);
   state_t state;
   logic [NUM_CH-1:0] elig, gnt, done_q;
   logic [CW-1:0] gnt_id, ch_q;
   logic [2:0] sel_size;
   logic [CNT_W-1:0] n_sel, n_q, c_q, c_nx;
   logic [ADDR_W-1:0] sel_addr, addr_q, nxt_addr, ram_addr_q;
   logic [DATA_W-1:0] sel_wdata, data_q, ext_data, rdata_q;
   logic sgn_q, sign_bit, stall, flushed, ram_we_q;
   logic [7:0] ram_dout_q;

   mem_arbiter_nch_arb_pick #(.NUM_CH(NUM_CH)) u_pick (
`ifdef MEM_ARB_RR_EN
      .clk(clk),
      .rst(rst),
      .adv(bus.rdy && state == IDLE),
`endif
      .req(elig),
      .gnt(gnt)
   );

   // request selection and per-beat address arithmetic; channels a flush would abort are not eligible
   always_comb begin
      elig = bus.req_valid_i & ~(bus.flush_i ? FLUSH_MASK : '0);
      gnt_id = '0;
      for (int i = 0; i < NUM_CH; i++) if (gnt[i]) gnt_id = CW'(i);
      sel_size = bus.req_size_i[gnt_id*3 +: 3];
      n_sel = sel_size == SZ_1 ? CNT_W'(1) : sel_size == SZ_2 ? CNT_W'(2) : CNT_W'(MAX_B);
      sel_addr = bus.req_addr_i[gnt_id*ADDR_W +: ADDR_W];
      sel_wdata = bus.req_wdata_i[gnt_id*DATA_W +: DATA_W];
      c_nx = c_q + CNT_W'(1);
      nxt_addr = addr_q + ADDR_W'(c_nx);
      stall = bus.io_full_i && addr_q[17:16] == IO_HI;
      flushed = bus.flush_i && FLUSH_MASK[ch_q];
   end

   // load result: bytes above the access size take the top loaded bit when signed, else zero
   always_comb begin
      sign_bit = 1'b0;
      ext_data = '0;
      for (int i = 0; i < MAX_B; i++) if (CNT_W'(i + 1) == n_q) sign_bit = sgn_q & data_q[8*i+7];
      for (int i = 0; i < MAX_B; i++) ext_data[8*i +: 8] = CNT_W'(i) < n_q ? data_q[8*i +: 8] : {8{sign_bit}};
   end

   // byte engine: one RAM beat per enabled edge, done pulse on the completion edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ch_q <= '0;
         addr_q <= '0;
         n_q <= '0;
         c_q <= '0;
         sgn_q <= 1'b0;
         data_q <= '0;
         done_q <= '0;
         rdata_q <= '0;
         ram_we_q <= 1'b0;
         ram_addr_q <= '0;
         ram_dout_q <= '0;
      end else if (bus.rdy) begin
         done_q <= '0;
         case (state)
            IDLE: if (|gnt) begin
               ch_q <= gnt_id;
               addr_q <= sel_addr;
               n_q <= n_sel;
               c_q <= '0;
               sgn_q <= bus.req_signed_i[gnt_id];
               data_q <= bus.req_we_i[gnt_id] == FLAG_WRITE ? sel_wdata : '0;
               ram_addr_q <= sel_addr;
               ram_we_q <= bus.req_we_i[gnt_id];
               ram_dout_q <= bus.req_we_i[gnt_id] == FLAG_WRITE ? sel_wdata[7:0] : 8'h00;
               state <= bus.req_we_i[gnt_id] == FLAG_WRITE ? WR : RD;
            end
            RD: if (flushed) begin
               state <= IDLE;
               ram_addr_q <= '0;
            end else if (c_q == n_q) begin
               state <= IDLE;
               ram_addr_q <= '0;
               done_q <= NUM_CH'(1) << ch_q;
               rdata_q <= ext_data;
            end else begin
               data_q[8*c_q +: 8] <= bus.ram_din_i;
               c_q <= c_nx;
               if (c_nx < n_q) ram_addr_q <= nxt_addr;
            end
            WR: if (!stall) begin
               if (c_nx < n_q) begin
                  ram_addr_q <= nxt_addr;
                  ram_dout_q <= data_q[8*c_nx +: 8];
                  c_q <= c_nx;
               end else begin
                  state <= IDLE;
                  ram_we_q <= 1'b0;
                  ram_addr_q <= '0;
                  ram_dout_q <= '0;
                  done_q <= NUM_CH'(1) << ch_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ram_we_o = ram_we_q;
   assign bus.ram_addr_o = ram_addr_q;
   assign bus.ram_dout_o = ram_dout_q;
   assign bus.done_o = done_q & {NUM_CH{bus.rdy}};
   assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: randomized self-checking bench for mem_arbiter_nch against a behavioural RAM/access model
module tb_mem_arbiter_nch;
   localparam int NUM_CH = 2;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;
   logic [7:0] ram [0:262143];
   logic [31:0] addr_log [0:63];
   logic [31:0] rdata_log [0:63];

   mem_arbiter_nch_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   mem_arbiter_nch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   assign bus.ram_din_i = ram[bus.ram_addr_o[17:0]];
   always @(posedge clk) if (bus.ram_we_o) ram[bus.ram_addr_o[17:0]] <= bus.ram_dout_o;

   function automatic int n_of(logic [2:0] sz);
      return sz == 3'd1 ? 1 : sz == 3'd2 ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_read(logic [31:0] a, logic [2:0] sz, bit sg);
      int n;
      logic [63:0] v;
      logic [31:0] ai;
      n = n_of(sz);
      v = '0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         v = v | (64'(ram[ai[17:0]]) << (8 * i));
      end
      if (sg && v[8*n-1]) v = v | (~64'd0 << (8 * n));
      return v[31:0];
   endfunction

   function automatic int pick(logic [NUM_CH-1:0] req, int last);
`ifdef MEM_ARB_RR_EN
      for (int i = 1; i <= NUM_CH; i++) if (req[(last + i) % NUM_CH]) return (last + i) % NUM_CH;
`else
      for (int i = 0; i < NUM_CH; i++) if (req[i]) return i;
`endif
      return -1;
   endfunction

   task automatic set_req(input int ch, input bit we, input bit sg, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      bus.req_we_i[ch] = we;
      bus.req_signed_i[ch] = sg;
      bus.req_size_i[ch*3 +: 3] = sz;
      bus.req_addr_i[ch*32 +: 32] = a;
      bus.req_wdata_i[ch*32 +: 32] = wd;
   endtask

   task automatic do_access(input int ch, input bit we, input bit sg, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input int io_cyc, input int rdy_cyc, input int flush_at,
                            output int cnt, output logic [31:0] rd, output bit got);
      set_req(ch, we, sg, sz, a, wd);
      bus.req_valid_i[ch] = 1'b1;
      cnt = 0;
      got = 1'b0;
      rd = '0;
      while (cnt < 24 && !got) begin
         bus.flush_i = (cnt + 1 == flush_at);
         @(posedge clk);
         #1;
         cnt++;
         addr_log[cnt] = bus.ram_addr_o;
         rdata_log[cnt] = bus.rdata_o;
         if (bus.done_o[ch]) begin
            got = 1'b1;
            rd = bus.rdata_o;
         end
         bus.flush_i = 1'b0;
         bus.io_full_i = cnt <= io_cyc;
         bus.rdy = !(cnt >= 2 && cnt < 2 + rdy_cyc);
         if (flush_at >= 2 && cnt == flush_at) bus.req_valid_i[ch] = 1'b0;
      end
      bus.req_valid_i[ch] = 1'b0;
      bus.io_full_i = 1'b0;
      bus.rdy = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 3'd4, 32'h123, 32'hDEADBEEF);
      bus.req_valid_i = 2'b01;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.ram_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.ram_we_o); end
      checks++; if (bus.ram_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.ram_addr_o); end
      checks++; if (bus.ram_dout_o !== 8'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.ram_dout_o); end
      checks++; if (bus.done_o !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
      checks++; if (bus.rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
      bus.req_valid_i = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_arbitration();
      int last, exp_ch, n_done;
      logic [NUM_CH-1:0] want;
      last = NUM_CH - 1;
      ram[18'h40] = 8'h3C;
      ram[18'h41] = 8'hC3;
      set_req(0, 1'b0, 1'b0, 3'd1, 32'h40, 32'h0);
      set_req(1, 1'b0, 1'b0, 3'd1, 32'h41, 32'h0);
      n_done = 0;
      bus.req_valid_i = 2'b11;
      for (int t = 0; t < 40 && n_done < 3; t++) begin
         @(posedge clk);
         #1;
         if (bus.done_o != 0) begin
            exp_ch = pick(2'b11, last);
            last = exp_ch;
            checks++; if (bus.done_o !== NUM_CH'(1) << exp_ch) begin failures++; $display("FAIL arb_held_grant got=%b exp_ch=%0d", bus.done_o, exp_ch); end
            checks++; if (bus.rdata_o !== exp_read(32'h40 + 32'(exp_ch), 3'd1, 1'b0)) begin failures++; $display("FAIL arb_held_rdata got=%h exp=%h", bus.rdata_o, exp_read(32'h40 + 32'(exp_ch), 3'd1, 1'b0)); end
            n_done++;
            if (n_done == 3) bus.req_valid_i = '0;
         end
      end
      bus.req_valid_i = '0;
      checks++; if (n_done != 3) begin failures++; $display("FAIL arb_held_count got=%0d exp=3", n_done); end
      want = 2'b11;
      n_done = 0;
      bus.req_valid_i = want;
      for (int t = 0; t < 40 && n_done < 2; t++) begin
         @(posedge clk);
         #1;
         if (bus.done_o != 0) begin
            exp_ch = pick(want, last);
            last = exp_ch;
            checks++; if (bus.done_o !== NUM_CH'(1) << exp_ch) begin failures++; $display("FAIL arb_drop_grant got=%b exp_ch=%0d", bus.done_o, exp_ch); end
            want = want & ~bus.done_o;
            bus.req_valid_i = want;
            n_done++;
         end
      end
      bus.req_valid_i = '0;
      checks++; if (n_done != 2) begin failures++; $display("FAIL arb_drop_count got=%0d exp=2", n_done); end
   endtask

   task automatic test_load_basic();
      int cnt;
      logic [31:0] rd;
      bit got;
      ram[18'h100] = 8'h78; ram[18'h101] = 8'h56; ram[18'h102] = 8'h34; ram[18'h103] = 8'h12;
      do_access(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 0, cnt, rd, got);
      checks++; if (!got || cnt != 6) begin failures++; $display("FAIL load_latency got=%0d done=%0b exp=6", cnt, got); end
      checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL load_rdata got=%h exp=12345678", rd); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (addr_log[k+1] !== 32'h100 + 32'(k)) begin failures++; $display("FAIL load_addr%0d got=%h exp=%h", k, addr_log[k+1], 32'h100 + 32'(k)); end
      end
   endtask

   task automatic test_sign();
      int cnt;
      logic [31:0] rd;
      bit got;
      ram[18'h80] = 8'h80;
      do_access(0, 1'b0, 1'b1, 3'd1, 32'h80, 32'h0, 0, 0, 0, cnt, rd, got);
      checks++; if (!got || rd !== 32'hFFFFFF80 || cnt != 3) begin failures++; $display("FAIL sign_ext got=%h cnt=%0d exp=ffffff80 cnt=3", rd, cnt); end
      do_access(0, 1'b0, 1'b0, 3'd1, 32'h80, 32'h0, 0, 0, 0, cnt, rd, got);
      checks++; if (!got || rd !== 32'h00000080) begin failures++; $display("FAIL zero_ext got=%h exp=00000080", rd); end
   endtask

   task automatic test_io_stall();
      int cnt;
      logic [31:0] rd;
      bit got;
      ram[18'h30000] = 8'h00; ram[18'h30001] = 8'h00; ram[18'h30002] = 8'h5A;
      do_access(0, 1'b1, 1'b0, 3'd2, 32'h30000, 32'hAABBCCDD, 3, 0, 0, cnt, rd, got);
      checks++; if (!got || cnt != 6) begin failures++; $display("FAIL io_stall_latency got=%0d done=%0b exp=6", cnt, got); end
      checks++; if (ram[18'h30000] !== 8'hDD) begin failures++; $display("FAIL io_byte0 got=%h exp=dd", ram[18'h30000]); end
      checks++; if (ram[18'h30001] !== 8'hCC) begin failures++; $display("FAIL io_byte1 got=%h exp=cc", ram[18'h30001]); end
      checks++; if (ram[18'h30002] !== 8'h5A) begin failures++; $display("FAIL io_byte2 got=%h exp=5a", ram[18'h30002]); end
   endtask

   task automatic test_flush();
      int cnt;
      logic [31:0] rd;
      bit got;
      do_access(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 2, cnt, rd, got);
      checks++; if (got) begin failures++; $display("FAIL flush_rd_done got=1 exp=0"); end
      checks++; if (addr_log[2] !== 32'h0) begin failures++; $display("FAIL flush_rd_addr got=%h exp=0", addr_log[2]); end
      do_access(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 0, cnt, rd, got);
      checks++; if (!got || cnt != 6 || rd !== exp_read(32'h100, 3'd4, 1'b0)) begin failures++; $display("FAIL flush_recover got=%h cnt=%0d exp=%h cnt=6", rd, cnt, exp_read(32'h100, 3'd4, 1'b0)); end
      do_access(0, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 2, cnt, rd, got);
      checks++; if (!got || cnt != 6 || rd !== exp_read(32'h100, 3'd4, 1'b0)) begin failures++; $display("FAIL flush_unmasked got=%h cnt=%0d exp=%h cnt=6", rd, cnt, exp_read(32'h100, 3'd4, 1'b0)); end
      do_access(1, 1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1, cnt, rd, got);
      checks++; if (!got || cnt != 5) begin failures++; $display("FAIL flush_idle got=%0d done=%0b exp=5", cnt, got); end
      do_access(0, 1'b1, 1'b0, 3'd4, 32'h500, 32'h11223344, 0, 0, 2, cnt, rd, got);
      checks++; if (!got || cnt != 5) begin failures++; $display("FAIL flush_wr0_done got=%0d done=%0b exp=5", cnt, got); end
      checks++; if (exp_read(32'h500, 3'd4, 1'b0) !== 32'h11223344) begin failures++; $display("FAIL flush_wr0_data got=%h exp=11223344", exp_read(32'h500, 3'd4, 1'b0)); end
      do_access(1, 1'b1, 1'b0, 3'd4, 32'h600, 32'h55667788, 0, 0, 2, cnt, rd, got);
      checks++; if (!got || cnt != 5 || exp_read(32'h600, 3'd4, 1'b0) !== 32'h55667788) begin failures++; $display("FAIL flush_wr1 cnt=%0d data=%h exp=5 55667788", cnt, exp_read(32'h600, 3'd4, 1'b0)); end
   endtask

   task automatic test_rdy();
      int cnt;
      logic [31:0] rd, prev, expv;
      bit got;
      ram[18'h80] = 8'h80;
      prev = 32'hFFFFFF80;
      do_access(0, 1'b0, 1'b1, 3'd1, 32'h80, 32'h0, 0, 0, 0, cnt, rd, got);
      expv = exp_read(32'h200, 3'd4, 1'b0);
      do_access(0, 1'b0, 1'b0, 3'd4, 32'h200, 32'h0, 0, 4, 0, cnt, rd, got);
      checks++; if (!got || cnt != 10) begin failures++; $display("FAIL rdy_latency got=%0d done=%0b exp=10", cnt, got); end
      checks++; if (addr_log[6] !== 32'h201) begin failures++; $display("FAIL rdy_addr_frozen got=%h exp=201", addr_log[6]); end
      checks++; if (rdata_log[6] !== prev) begin failures++; $display("FAIL rdy_rdata_hold got=%h exp=%h", rdata_log[6], prev); end
      checks++; if (rd !== expv) begin failures++; $display("FAIL rdy_rdata got=%h exp=%h", rd, expv); end
   endtask

   task automatic test_reset_mid();
      int cnt;
      logic [31:0] rd;
      bit got;
      set_req(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0);
      bus.req_valid_i[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.ram_addr_o !== 32'h0 || bus.ram_we_o !== 1'b0 || bus.ram_dout_o !== 8'h0) begin failures++; $display("FAIL rst_mid_ram addr=%h we=%b dout=%h exp=0", bus.ram_addr_o, bus.ram_we_o, bus.ram_dout_o); end
      checks++; if (bus.done_o !== 2'b00 || bus.rdata_o !== 32'h0) begin failures++; $display("FAIL rst_mid_out done=%b rdata=%h exp=0", bus.done_o, bus.rdata_o); end
      bus.req_valid_i = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_access(1, 1'b0, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 0, cnt, rd, got);
      checks++; if (!got || cnt != 6 || rd !== exp_read(32'h100, 3'd4, 1'b0)) begin failures++; $display("FAIL rst_mid_recover got=%h cnt=%0d exp=%h", rd, cnt, exp_read(32'h100, 3'd4, 1'b0)); end
   endtask

   task automatic test_random();
      int cnt, ch, n, lat;
      logic [31:0] rd, a, wd, expv, ai;
      logic [2:0] sz;
      logic [7:0] after;
      bit got, we, sg;
      logic [2:0] sizes [6];
      sizes = '{3'd1, 3'd2, 3'd4, 3'd0, 3'd3, 3'd7};
      for (int it = 0; it < 24; it++) begin
         ch = $urandom_range(0, NUM_CH - 1);
         we = 1'($urandom);
         sg = 1'($urandom);
         sz = sizes[$urandom_range(0, 5)];
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFE : 32'($urandom_range(0, 32'h3FFFF));
         wd = $urandom;
         n = n_of(sz);
         ai = a + 32'(n);
         after = ram[ai[17:0]];
         expv = exp_read(a, sz, sg);
         lat = we ? n + 1 : n + 2;
         do_access(ch, we, sg, sz, a, wd, 0, 0, 0, cnt, rd, got);
         checks++; if (!got || cnt != lat) begin failures++; $display("FAIL rand_latency it=%0d got=%0d done=%0b exp=%0d", it, cnt, got, lat); end
         if (we) begin
            checks++; if (exp_read(a, sz, 1'b0) !== (n == 4 ? wd : wd & ((32'd1 << (8 * n)) - 1))) begin failures++; $display("FAIL rand_store it=%0d got=%h wd=%h n=%0d", it, exp_read(a, sz, 1'b0), wd, n); end
            checks++; if (ram[ai[17:0]] !== after) begin failures++; $display("FAIL rand_store_over it=%0d got=%h exp=%h", it, ram[ai[17:0]], after); end
         end else begin
            checks++; if (rd !== expv) begin failures++; $display("FAIL rand_load it=%0d got=%h exp=%h", it, rd, expv); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.rdy = 1'b1;
      bus.flush_i = 1'b0;
      bus.io_full_i = 1'b0;
      bus.req_valid_i = '0;
      bus.req_we_i = '0;
      bus.req_signed_i = '0;
      bus.req_size_i = '0;
      bus.req_addr_i = '0;
      bus.req_wdata_i = '0;
      for (int i = 0; i < 262144; i++) ram[i] = 8'($urandom);
      test_reset();
      test_arbitration();
      test_load_basic();
      test_sign();
      test_io_stall();
      test_flush();
      test_rdy();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end
endmodule
